// File: rtl/read_image_v2.sv
// read_image_v2: binary 3x3 median filter sequencer.
// Scans every window of a 1-bit image in external RAM and emits the majority bit per window.
module read_image_v2 #(
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int WINDOWSIZE  = 3,
  parameter int MEDIANVALUE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dataIn,
  output logic [7:0]  xAddressOut,
  output logic [7:0]  yAddressOut,
  output logic [12:0] activeWindows,
  output logic        medianDataOut,
  output logic        fullImageDone
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [1:0] LAST_IDX = 2'(WINDOWSIZE - 1);
  localparam logic [7:0] LAST_WX  = 8'(IMG_WIDTH - WINDOWSIZE);
  localparam logic [7:0] LAST_WY  = 8'(IMG_HEIGHT - WINDOWSIZE);
  localparam logic [3:0] THRESH   = 4'(MEDIANVALUE);
  state_t state, nextState;
  logic [1:0] colCount, rowCount, nextCol, nextRow;
  logic [7:0] wx, wy, nextWx, nextWy;
  logic [3:0] sum, total;
  logic lastPixel, lastWindow;
  always_ff @(posedge clk)
    state <= reset ? IDLE : nextState;
  always_comb
    nextState = (state == IDLE && start) ? SCAN :
                (state == SCAN && lastPixel && lastWindow) ? DONE : state;
  // The pixel after a window's last one is the next window's first: no bubble.
  always_comb begin
    lastPixel  = colCount == LAST_IDX && rowCount == LAST_IDX;
    lastWindow = wx == LAST_WX && wy == LAST_WY;
    nextCol    = colCount == LAST_IDX ? 2'd0 : colCount + 2'd1;
    nextRow    = colCount != LAST_IDX ? rowCount : rowCount == LAST_IDX ? 2'd0 : rowCount + 2'd1;
    nextWx     = !lastPixel ? wx : wx == LAST_WX ? 8'd0 : wx + 8'd1;
    nextWy     = (!lastPixel || wx != LAST_WX) ? wy : wy == LAST_WY ? 8'd0 : wy + 8'd1;
    total      = sum + {3'd0, dataIn};
  end
  // IDLE is only reachable through reset, so the cleared datapath already addresses (0,0).
  always_ff @(posedge clk)
    if (reset) begin
      colCount      <= 2'd0;
      rowCount      <= 2'd0;
      wx            <= 8'd0;
      wy            <= 8'd0;
      sum           <= 4'd0;
      xAddressOut   <= 8'd0;
      yAddressOut   <= 8'd0;
      activeWindows <= 13'd0;
      medianDataOut <= 1'b0;
      fullImageDone <= 1'b0;
    end else if (state == SCAN) begin
      colCount    <= nextCol;
      rowCount    <= nextRow;
      wx          <= nextWx;
      wy          <= nextWy;
      xAddressOut <= nextWx + {6'd0, nextCol};
      yAddressOut <= nextWy + {6'd0, nextRow};
      sum         <= lastPixel ? 4'd0 : total;
      if (lastPixel) begin
        medianDataOut <= total > THRESH;
        activeWindows <= activeWindows + 13'd1;
        fullImageDone <= lastWindow;
      end
    end
endmodule

// File: tb/tb_read_image_v2.sv
// tb_read_image_v2: randomized bench comparing read_image_v2 (5x5 and 64x64)
// against a window-level reference model of scan order and majority medians.
module tb_read_image_v2;
  localparam int SW = 5, SN = (SW - 2) * (SW - 2);
  localparam int BW = 64, BN = (BW - 2) * (BW - 2);
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, dataIn, bReset, bStart, bDataIn;
  logic [7:0] xAddr, yAddr, bxAddr, byAddr;
  logic [12:0] windows, bWindows;
  logic median, done, bMedian, bDone;
  int tests = 0, fails = 0;
  logic stream [9*SN];
  logic img [BW][BW];

  read_image_v2 #(.IMG_WIDTH(SW), .IMG_HEIGHT(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .dataIn(dataIn),
    .xAddressOut(xAddr), .yAddressOut(yAddr), .activeWindows(windows),
    .medianDataOut(median), .fullImageDone(done)
  );
  read_image_v2 dutBig (
    .clk(clk), .reset(bReset), .start(bStart), .dataIn(bDataIn),
    .xAddressOut(bxAddr), .yAddressOut(byAddr), .activeWindows(bWindows),
    .medianDataOut(bMedian), .fullImageDone(bDone)
  );

  function automatic void addrOf(input int w, input int k, output int x, output int y);
    int n = k / 9, j = k % 9;
    if (n >= (w - 2) * (w - 2)) begin
      x = 0;
      y = 0;
    end else begin
      x = n % (w - 2) + j % 3;
      y = n / (w - 2) + j / 3;
    end
  endfunction

  function automatic logic streamMedian(input int m);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(stream[9*m+i]);
    return s > 4;
  endfunction

  function automatic logic imgMedian(input int m);
    int s = 0, ox = m % (BW - 2), oy = m / (BW - 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) s += int'(img[oy+r][ox+c]);
    return s > 4;
  endfunction

  task automatic runSmall(input int stopAt);
    int x, y, n;
    logic em;
    reset = 1'b1; start = 1'b0; dataIn = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 9 * SN + 3; k++) begin
      addrOf(SW, k, x, y);
      n = k / 9 > SN ? SN : k / 9;
      em = n == 0 ? 1'b0 : streamMedian(n - 1);
      tests++;
      if (xAddr !== 8'(x) || yAddr !== 8'(y)) begin
        fails++;
        $display("FAIL addr E%0d got (%0d,%0d) want (%0d,%0d)", k, xAddr, yAddr, x, y);
      end
      tests++;
      if (windows !== 13'(n)) begin
        fails++;
        $display("FAIL activeWindows E%0d got %0d want %0d", k, windows, n);
      end
      tests++;
      if (median !== em) begin
        fails++;
        $display("FAIL median E%0d got %b want %b", k, median, em);
      end
      tests++;
      if (done !== 1'(k >= 9 * SN)) begin
        fails++;
        $display("FAIL fullImageDone E%0d got %b want %b", k, done, k >= 9 * SN);
      end
      dataIn = k < 9 * SN ? stream[k] : 1'($urandom);
      if (k == stopAt - 1) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dataIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({xAddr, yAddr, windows, median, done} !== '0) begin
      fails++;
      $display("FAIL reset_state got x=%0d y=%0d w=%0d m=%b d=%b want all 0", xAddr, yAddr, windows, median, done);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({xAddr, yAddr, windows, done} !== '0) begin
      fails++;
      $display("FAIL idle_hold got x=%0d y=%0d w=%0d d=%b want all 0", xAddr, yAddr, windows, done);
    end
  endtask

  task automatic test_random_scan();
    foreach (stream[i]) stream[i] = 1'($urandom);
    runSmall(-1);
  endtask

  task automatic test_all_ones();
    foreach (stream[i]) stream[i] = 1'b1;
    runSmall(-1);
  endtask

  task automatic test_all_zeros();
    foreach (stream[i]) stream[i] = 1'b0;
    runSmall(-1);
  endtask

  task automatic test_median_threshold();
    foreach (stream[i]) stream[i] = 1'($urandom);
    for (int i = 0; i < 9; i++) stream[i] = 1'(i < 4);
    for (int i = 0; i < 9; i++) stream[9+i] = 1'(i < 5);
    runSmall(-1);
  endtask

  task automatic test_reset_mid_scan();
    foreach (stream[i]) stream[i] = 1'b1;
    runSmall(40);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({xAddr, yAddr, windows, median, done} !== '0) begin
      fails++;
      $display("FAIL mid_reset got x=%0d y=%0d w=%0d m=%b d=%b want all 0", xAddr, yAddr, windows, median, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({xAddr, yAddr, windows, done} !== '0) begin
        fails++;
        $display("FAIL mid_reset_idle cycle %0d got x=%0d y=%0d w=%0d d=%b want all 0", i, xAddr, yAddr, windows, done);
      end
    end
  endtask

  task automatic test_full_image_64();
    int x, y, n;
    logic em;
    foreach (img[i, j]) img[i][j] = 1'($urandom);
    bReset = 1'b1; bStart = 1'b0; bDataIn = 1'b0;
    @(posedge clk); #1;
    bReset = 1'b0; bStart = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 9 * BN + 2; k++) begin
      addrOf(BW, k, x, y);
      n = k / 9 > BN ? BN : k / 9;
      em = n == 0 ? 1'b0 : imgMedian(n - 1);
      tests++;
      if (bxAddr !== 8'(x) || byAddr !== 8'(y) || bWindows !== 13'(n) || bMedian !== em || bDone !== 1'(k >= 9 * BN)) begin
        fails++;
        $display("FAIL big E%0d got (%0d,%0d) w=%0d m=%b d=%b want (%0d,%0d) w=%0d m=%b d=%b",
                 k, bxAddr, byAddr, bWindows, bMedian, bDone, x, y, n, em, k >= 9 * BN);
      end
      bDataIn = k < 9 * BN ? img[y][x] : 1'b0;
      @(posedge clk); #1;
    end
    bStart = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dataIn = 1'b0;
    bReset = 1'b1; bStart = 1'b0; bDataIn = 1'b0;
    test_reset();
    test_random_scan();
    test_all_ones();
    test_all_zeros();
    test_median_threshold();
    test_reset_mid_scan();
    test_random_scan();
    test_full_image_64();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
